// File: rtl/sample_stream_analyzer_if.sv
// Stream and result bundle for sample_stream_analyzer: the master feeds samples
// and start requests, the slave (the analyzer) returns status and window results.
interface sample_stream_analyzer_if #(
   parameter int DATA_W  = 24,
   parameter int WIN_LEN = 1024
);
   localparam int CNT_W = $clog2(WIN_LEN + 1);

   logic                     start_i;
   logic signed [DATA_W-1:0] sample_i;
   logic                     sample_valid_i;
   logic                     busy_o;
   logic                     done_o;
   logic signed [DATA_W-1:0] max_o;
   logic signed [DATA_W-1:0] min_o;
   logic [CNT_W-1:0]         zc_cnt_o;
   logic [CNT_W-1:0]         period_o;

   modport master (
      output start_i, sample_i, sample_valid_i,
      input  busy_o, done_o, max_o, min_o, zc_cnt_o, period_o
   );

   modport slave (
      input  start_i, sample_i, sample_valid_i,
      output busy_o, done_o, max_o, min_o, zc_cnt_o, period_o
   );
endinterface

// File: rtl/sample_stream_analyzer.sv
// Windowed peak / rising zero-crossing / period analyzer for a signed sample stream.
// Define ZC_HYST_EN to qualify crossings with +/-HYST hysteresis instead of a plain sign change.
module sample_stream_analyzer #(
   parameter int DATA_W  = 24,
   parameter int WIN_LEN = 1024,
   parameter int HYST    = 256
) (
   input logic                     clk,
   input logic                     rst_ni,
   sample_stream_analyzer_if.slave bus
);
   localparam int CNT_W = $clog2(WIN_LEN + 1);
   localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_LEN);

   if (WIN_LEN < 2 || HYST < 0) begin : g_param_check
      $error("sample_stream_analyzer: WIN_LEN must be >= 2 and HYST >= 0");
   end

   typedef enum logic [1:0] {IDLE, MEAS, DONE} state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         smp_cnt_q;
   logic [CNT_W-1:0]         zc_q;
   logic [CNT_W-1:0]         per_cnt_q;
   logic [CNT_W-1:0]         per_res_q;
   logic signed [DATA_W-1:0] run_max_q;
   logic signed [DATA_W-1:0] run_min_q;
   logic                     seen_zc_q;
   logic                     prev_neg_q;

   logic signed [DATA_W-1:0] max_q, min_q;
   logic [CNT_W-1:0]         zc_out_q, per_out_q;

   logic accept;
   logic first_smp;
   logic last_smp;
   logic rise;

   assign accept    = (state_q == MEAS) && bus.sample_valid_i;
   assign first_smp = (smp_cnt_q == '0);
   assign last_smp  = accept && (smp_cnt_q == WIN_CNT - 1'b1);

`ifdef ZC_HYST_EN
   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;

   logic arm_q;

   // The arm flag starts cleared each window, so the first sample can never count.
   assign rise = accept && arm_q && (bus.sample_i >= HYST_POS);

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         arm_q <= 1'b0;
      end else if (state_q == IDLE && bus.start_i) begin
         arm_q <= 1'b0;
      end else if (rise) begin
         arm_q <= 1'b0;
      end else if (accept && bus.sample_i <= HYST_NEG) begin
         arm_q <= 1'b1;
      end
   end
`else
   assign rise = accept && !first_smp && prev_neg_q && !bus.sample_i[DATA_W-1];
`endif

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start_i) state_d = MEAS;
         MEAS:    if (last_smp)    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         smp_cnt_q  <= '0;
         zc_q       <= '0;
         per_cnt_q  <= '0;
         per_res_q  <= '0;
         run_max_q  <= '0;
         run_min_q  <= '0;
         seen_zc_q  <= 1'b0;
         prev_neg_q <= 1'b0;
      end else if (state_q == IDLE && bus.start_i) begin
         smp_cnt_q  <= '0;
         zc_q       <= '0;
         per_cnt_q  <= '0;
         per_res_q  <= '0;
         run_max_q  <= '0;
         run_min_q  <= '0;
         seen_zc_q  <= 1'b0;
         prev_neg_q <= 1'b0;
      end else if (accept) begin
         smp_cnt_q  <= smp_cnt_q + 1'b1;
         prev_neg_q <= bus.sample_i[DATA_W-1];

         if (first_smp || bus.sample_i > run_max_q) run_max_q <= bus.sample_i;
         if (first_smp || bus.sample_i < run_min_q) run_min_q <= bus.sample_i;

         if (rise) begin
            if (zc_q != WIN_CNT) zc_q <= zc_q + 1'b1;
            if (seen_zc_q)       per_res_q <= per_cnt_q;
            seen_zc_q <= 1'b1;
            per_cnt_q <= CNT_W'(1);
         end else if (per_cnt_q != WIN_CNT) begin
            per_cnt_q <= per_cnt_q + 1'b1;
         end
      end
   end

   // Results only move in DONE, so they stay stable for the whole next window.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q     <= '0;
         min_q     <= '0;
         zc_out_q  <= '0;
         per_out_q <= '0;
      end else if (state_q == DONE) begin
         max_q     <= run_max_q;
         min_q     <= run_min_q;
         zc_out_q  <= zc_q;
         per_out_q <= per_res_q;
      end
   end

   assign bus.busy_o   = (state_q == MEAS);
   assign bus.done_o   = (state_q == DONE);
   assign bus.max_o    = max_q;
   assign bus.min_o    = min_q;
   assign bus.zc_cnt_o = zc_out_q;
   assign bus.period_o = per_out_q;

endmodule

// File: tb/tb_sample_stream_analyzer.sv
// Scoreboard bench for sample_stream_analyzer with WIN_LEN=64; expected window
// results are queued as each window is driven and compared when done_o fires.
module tb_sample_stream_analyzer;
   localparam int DATA_W  = 24;
   localparam int WIN_LEN = 64;
   localparam int CNT_W   = $clog2(WIN_LEN + 1);

   typedef logic signed [DATA_W-1:0] smp_t;
   typedef struct packed {
      smp_t             mx;
      smp_t             mn;
      logic [CNT_W-1:0] zc;
      logic [CNT_W-1:0] per;
   } res_t;

   res_t exp_q[$];
   smp_t stim_q[$];
   int   errors = 0;
   int   checks = 0;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;

   always #5 clk = ~clk;

   sample_stream_analyzer_if #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN)) bus ();

   sample_stream_analyzer #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .HYST(256)) dut (
      .clk    (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic string fmt(input res_t r);
      return $sformatf("max=%0d min=%0d zc=%0d per=%0d", r.mx, r.mn, r.zc, r.per);
   endfunction

   function automatic res_t observe();
      res_t r;
      r.mx  = bus.max_o;
      r.mn  = bus.min_o;
      r.zc  = bus.zc_cnt_o;
      r.per = bus.period_o;
      return r;
   endfunction

   // kind 0: 8x(-1000),8x(+1000); kind 1: -100/+100 alternating; kind 2: extremes in positives
   task automatic make_stream(input int kind);
      stim_q.delete();
      for (int i = 0; i < WIN_LEN; i++) begin
         case (kind)
            0:       stim_q.push_back(((i / 8) % 2 == 0) ? -24'sd1000 : 24'sd1000);
            1:       stim_q.push_back((i % 2 == 0) ? -24'sd100 : 24'sd100);
            default: stim_q.push_back((i == 20) ? 24'sh800000 :
                                      (i == 40) ? 24'sh7FFFFF : 24'sd5);
         endcase
      end
   endtask

   // Drives one window; a junk sample rides along with start and must be ignored.
   // abort_at >= 0 stops feeding after that many samples and leaves the DUT mid-window.
   task automatic run_window(input bit gaps, input int start_at, input int abort_at,
                             output int lat, output int early, output res_t got,
                             output logic done_after);
      early = 0;
      got   = '0;
      done_after = 1'b0;
      bus.start_i        = 1'b1;
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = 24'sh7FFFFF;
      tick();
      bus.start_i = 1'b0;
      lat = 1;
      for (int i = 0; i < WIN_LEN; i++) begin
         if (i == abort_at) begin
            bus.sample_valid_i = 1'b0;
            lat = -1;
            return;
         end
         if (gaps && i > 0) begin
            bus.sample_valid_i = 1'b0;
            tick();
            lat++;
            if (bus.done_o === 1'b1) early++;
         end
         bus.start_i        = (i == start_at);
         bus.sample_valid_i = 1'b1;
         bus.sample_i       = stim_q[i];
         tick();
         lat++;
         bus.start_i = 1'b0;
         if (i < WIN_LEN - 1 && bus.done_o === 1'b1) early++;
      end
      bus.sample_valid_i = 1'b0;
      for (int w = 0; w < 8 && bus.done_o !== 1'b1; w++) begin
         tick();
         lat++;
      end
      if (bus.done_o !== 1'b1) lat = -1;
      tick();
      done_after = bus.done_o;
      got = observe();
   endtask

   task automatic test_reset();
      res_t zero = '0;
      bus.start_i = 1'b0;
      bus.sample_valid_i = 1'b0;
      bus.sample_i = '0;
      for (int c = 0; c < 6; c++) begin
         bus.start_i        = c[0];
         bus.sample_valid_i = ~c[0];
         bus.sample_i       = DATA_W'($urandom);
         tick();
         checks++;
         if (observe() !== zero || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %s busy=%b done=%b, expected all zero",
                     fmt(observe()), bus.busy_o, bus.done_o);
         end
      end
      bus.start_i = 1'b0;
      rst_ni = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.sample_valid_i = 1'b1;
         bus.sample_i       = DATA_W'($urandom);
         tick();
         checks++;
         if (observe() !== zero || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got %s busy=%b done=%b, expected all zero",
                     fmt(observe()), bus.busy_o, bus.done_o);
         end
      end
      bus.sample_valid_i = 1'b0;
   endtask

   task automatic check_window(input string name, input bit gaps, input int start_at,
                               input int exp_lat);
      int   lat, early;
      res_t got, exp;
      logic done_after;
      run_window(gaps, start_at, -1, lat, early, got, done_after);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s_results: got %s, expected %s", name, fmt(got), fmt(exp));
      end
      checks++;
      if (lat != exp_lat || early != 0 || done_after !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_timing: got lat=%0d early=%0d width2=%b, expected lat=%0d early=0 width2=0",
                  name, lat, early, done_after, exp_lat);
      end
   endtask

   task automatic test_square();
      make_stream(0);
      exp_q.push_back('{24'sd1000, -24'sd1000, 7'd4, 7'd16});
      check_window("square", 1'b0, -1, 65);
   endtask

   task automatic test_gaps();
      make_stream(0);
      exp_q.push_back('{24'sd1000, -24'sd1000, 7'd4, 7'd16});
      check_window("gaps", 1'b1, -1, 128);
   endtask

   task automatic test_start_and_reset();
      int   lat, early;
      res_t got;
      logic done_after;
      res_t zero = '0;
      make_stream(0);
      exp_q.push_back('{24'sd1000, -24'sd1000, 7'd4, 7'd16});
      check_window("start_in_meas", 1'b0, 9, 65);
      run_window(1'b0, -1, 29, lat, early, got, done_after);
      checks++;
      if (bus.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL busy_mid_window: got busy=%b, expected 1", bus.busy_o);
      end
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = stim_q[29];
      rst_ni = 1'b0;
      #1;
      checks++;
      if (observe() !== zero || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_window: got %s busy=%b done=%b, expected all zero",
                  fmt(observe()), bus.busy_o, bus.done_o);
      end
      bus.sample_valid_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      exp_q.push_back('{24'sd1000, -24'sd1000, 7'd4, 7'd16});
      check_window("after_reset", 1'b0, -1, 65);
   endtask

   task automatic test_alternating();
      make_stream(1);
`ifdef ZC_HYST_EN
      exp_q.push_back('{24'sd100, -24'sd100, 7'd0, 7'd0});
`else
      exp_q.push_back('{24'sd100, -24'sd100, 7'd32, 7'd2});
`endif
      check_window("alternating", 1'b0, -1, 65);
   endtask

   task automatic test_extremes();
      make_stream(2);
      exp_q.push_back('{24'sh7FFFFF, 24'sh800000, 7'd1, 7'd0});
      check_window("extremes", 1'b0, -1, 65);
   endtask

   task automatic test_back_to_back();
      make_stream(1);
`ifdef ZC_HYST_EN
      exp_q.push_back('{24'sd100, -24'sd100, 7'd0, 7'd0});
`else
      exp_q.push_back('{24'sd100, -24'sd100, 7'd32, 7'd2});
`endif
      check_window("b2b_first", 1'b1, -1, 128);
      make_stream(0);
      exp_q.push_back('{24'sd1000, -24'sd1000, 7'd4, 7'd16});
      check_window("b2b_second", 1'b0, -1, 65);
   endtask

   initial begin
      test_reset();
      test_square();
      test_gaps();
      test_start_and_reset();
      test_alternating();
      test_extremes();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sample_stream_analyzer.md
Name: sample_stream_analyzer

Overview:
- Sink-side counterpart to the LUT sine source.
- Consumes a stream of signed 24-bit samples, for example the FIR output or a test tone looped back.
- Over a window of WIN_LEN accepted samples, measures peak maximum, peak minimum, rising zero-crossing count and the period between rising crossings.
- Used on-chip to check filter response (attenuated vs passed tone) without a host capture.

Parameters:
- DATA_W, 24: sample width, two's-complement signed.
- WIN_LEN, 1024: valid samples per measurement window; must be >= 2.
- HYST, 256: hysteresis magnitude. Used only when ZC_HYST_EN is defined.

Ports:
- clk  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  single-cycle request to begin a window
- sample_i  input  DATA_W  signed sample
- sample_valid_i  input  1  sample_i qualifier; one sample accepted per cycle when high
- busy_o  output  1  high while a window is being measured
- done_o  output  1  one-cycle pulse when results update
- max_o  output  DATA_W  signed peak maximum of the last completed window
- min_o  output  DATA_W  signed peak minimum of the last completed window
- zc_cnt_o  output  CNT_W  rising zero crossings in the last window; CNT_W = $clog2(WIN_LEN+1)
- period_o  output  CNT_W  valid samples between the two most recent rising crossings; 0 if fewer than 2 crossings

Behaviour:
- Reset state:
  - FSM in IDLE.
  - All outputs and internal registers are 0.
  - Reset is asynchronous and takes effect mid-window too; any partial measurement is discarded.
- FSM states: IDLE, MEAS, DONE.
- IDLE:
  - start_i=1 moves to MEAS next cycle and clears the sample counter, running max/min, zc count, period counter, "seen crossing" flag and previous-sample sign.
  - A sample presented in the same cycle as start_i is ignored.
  - sample_valid_i is ignored in IDLE.
- MEAS:
  - busy_o=1.
  - Each cycle with sample_valid_i=1:
    - Sample counter increments.
    - First sample of the window initialises running max and min.
    - Later samples update max/min with a signed compare.
  - Cycles with sample_valid_i=0 change nothing; gaps are transparent.
  - Rising crossing: previous accepted sample < 0 and current sample >= 0. No crossing is possible on the first sample.
  - On a crossing:
    - zc count increments, saturating at WIN_LEN.
    - If a prior crossing exists, the period result = the period counter value, then the counter resets to 1.
    - Otherwise the "seen crossing" flag is set and the counter resets to 1.
  - The period counter increments on every other valid sample and saturates at WIN_LEN.
  - When the WIN_LEN-th sample is accepted (included in all statistics), move to DONE.
  - start_i is ignored while in MEAS.
- DONE (exactly one cycle):
  - done_o=1.
  - max_o, min_o, zc_cnt_o and period_o load from the running registers in this cycle and are visible from the next edge.
  - busy_o=0.
  - Go to IDLE.
  - start_i in DONE is ignored.
- Result outputs hold their values until the next DONE or reset.
- Latency: done_o asserts exactly 1 cycle after the cycle accepting the final sample.

Optional Feature:
- Macro: ZC_HYST_EN.
- Defined:
  - An internal arm flag sets when an accepted sample <= -HYST.
  - A rising crossing counts only when the arm flag is set and the sample >= +HYST; the arm flag then clears.
  - The period logic uses these qualified crossings.
- Undefined:
  - Plain sign-change detection as in Behaviour.
  - HYST is unused and no arm logic is generated.

Test Plan:
1. Reset with inputs toggling -> all outputs 0, busy_o=0, done_o=0; after release, samples without start_i leave outputs 0.
2. WIN_LEN=64, start, then 64 contiguous valid samples of repeating 8x(-1000), 8x(+1000) -> done_o pulse 1 cycle after the 64th sample; max_o=1000, min_o=-1000, zc_cnt_o=4 (crossings at samples 9, 25, 41, 57), period_o=16.
3. Same stream as test 2 with sample_valid_i low every other cycle -> identical results; done_o arrives 63 cycles later than in test 2.
4. start_i pulsed at sample 10 of a window -> ignored, results as test 2; rst_ni low at sample 30 of a new window -> busy_o=0, outputs 0 immediately; a fresh start then completes correctly.
5. WIN_LEN=64, alternating -100/+100 -> macro undefined: zc_cnt_o=32, period_o=2. ZC_HYST_EN with HYST=256: zc_cnt_o=0, period_o=0, max_o=100, min_o=-100.
6. Window containing 24'h800000 and 24'h7FFFFF, all positive otherwise -> min_o=-8388608, max_o=8388607, zc_cnt_o=1, period_o=0.
